// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the sync generator and the renderers.
package vga_timing_pkg;

  localparam int unsigned VGA_H_DISP  = 640;
  localparam int unsigned VGA_H_FP    = 16;
  localparam int unsigned VGA_H_SYNC  = 96;
  localparam int unsigned VGA_H_BP    = 48;
  localparam int unsigned VGA_V_DISP  = 480;
  localparam int unsigned VGA_V_FP    = 10;
  localparam int unsigned VGA_V_SYNC  = 2;
  localparam int unsigned VGA_V_BP    = 33;
  localparam int unsigned VGA_PIX_DIV = 2;
  localparam int unsigned VGA_CW      = 10;

  localparam int unsigned VGA_H_TOTAL  = VGA_H_DISP + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_DISP + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned VGA_HS_START = VGA_H_DISP + VGA_H_FP;
  localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
  localparam int unsigned VGA_VS_START = VGA_V_DISP + VGA_V_FP;
  localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

  // Inclusive range test used for sync windows and renderer bounds checks.
  function automatic logic in_window(input int unsigned v, input int unsigned lo,
                                     input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel clock-enable divider: p_tick is high one clk out of every PIX_DIV.
module vga_pix_tick #(
  parameter int unsigned PIX_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int unsigned DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  always_comb begin
    div_d = div_q + DW'(1);
    if (div_q == LAST) div_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  // Gated by reset so the tick is quiet while reset is held, even with PIX_DIV=1.
  assign p_tick = !reset && (div_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing master: pixel coordinates, sync pins, video_on and per-frame tick.
// Define VGA_SYNC_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISP  = VGA_H_DISP,
  parameter int unsigned H_FP    = VGA_H_FP,
  parameter int unsigned H_SYNC  = VGA_H_SYNC,
  parameter int unsigned H_BP    = VGA_H_BP,
  parameter int unsigned V_DISP  = VGA_V_DISP,
  parameter int unsigned V_FP    = VGA_V_FP,
  parameter int unsigned V_SYNC  = VGA_V_SYNC,
  parameter int unsigned V_BP    = VGA_V_BP,
  parameter int unsigned PIX_DIV = VGA_PIX_DIV,
  parameter int unsigned CW      = VGA_CW
) (
  input  logic          clk,
  input  logic          reset,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          p_tick,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          refr_tick
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0]    frame_cnt
`endif
);

  localparam int unsigned H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_DISP + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_DISP + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  logic [CW-1:0] x_d;
  logic [CW-1:0] y_d;
  logic          hsync_d;
  logic          vsync_d;
  logic          x_last;
  logic          y_last;

  vga_pix_tick #(
    .PIX_DIV(PIX_DIV)
  ) u_pix_tick (
    .clk   (clk),
    .reset (reset),
    .p_tick(p_tick)
  );

  assign x_last = (pix_x == CW'(H_TOTAL - 1));
  assign y_last = (pix_y == CW'(V_TOTAL - 1));

  // Next-state counters; sync pins are derived from them so they line up with pix_x/pix_y.
  always_comb begin
    x_d = pix_x;
    y_d = pix_y;
    if (p_tick) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : pix_y + CW'(1);
      end else begin
        x_d = pix_x + CW'(1);
      end
    end
    hsync_d = !in_window(32'(x_d), HS_START, HS_END);
    vsync_d = !in_window(32'(y_d), VS_START, VS_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_x <= '0;
      pix_y <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      pix_x <= x_d;
      pix_y <= y_d;
      hsync <= hsync_d;
      vsync <= vsync_d;
    end
  end

  assign video_on  = (pix_x < CW'(H_DISP)) && (pix_y < CW'(V_DISP));
  assign refr_tick = p_tick && (pix_x == '0) && (pix_y == CW'(V_DISP + 1));

`ifdef VGA_SYNC_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                          frame_cnt <= '0;
    else if (p_tick && x_last && y_last) frame_cnt <= frame_cnt + 8'(1);
  end
`endif

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing master for the VGA display path; produces the `pix_x`, `pix_y`, `video_on` and `refr_tick` signals consumed by every sprite/logo renderer.
- Also produces the `hsync`/`vsync` pins for the connector.
- Default mode is 640x480 at 60 Hz, with a 25 MHz pixel rate derived from a 50 MHz system clock through a clock-enable divider (no derived clocks).

Parameters:
- `H_DISP`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_DISP`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `PIX_DIV`, 2, system clocks per pixel (≥1)
- `CW`, 10, coordinate counter width

Ports:
- `clk`  in  1  system clock (50 MHz)
- `reset`  in  1  synchronous, active-high reset
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `video_on`  out  1  high while the current pixel is in the visible area
- `p_tick`  out  1  one-clk pulse; counters advance on the clock edge where it is high
- `pix_x`  out  `CW`  current horizontal count, 0..`H_TOTAL`-1
- `pix_y`  out  `CW`  current vertical count, 0..`V_TOTAL`-1
- `refr_tick`  out  1  one-clk pulse once per frame, at start of vertical blanking

Behaviour:
- Derived constants:
  - `H_TOTAL` = `H_DISP`+`H_FP`+`H_SYNC`+`H_BP` (800)
  - `V_TOTAL` = `V_DISP`+`V_FP`+`V_SYNC`+`V_BP` (525)
- Reset (sync, active-high):
  - divider=0, `pix_x`=0, `pix_y`=0, `p_tick`=0.
  - `hsync`=1, `vsync`=1 (deasserted), `refr_tick`=0.
  - `video_on`=1 is permitted, since (0,0) is visible.
  - Reset asserted mid-frame restarts at (0,0) on the next edge, with no partial sync pulse beyond that edge.
- Divider:
  - Counts 0..`PIX_DIV`-1 and wraps.
  - `p_tick` is asserted combinationally when divider==`PIX_DIV`-1.
  - With `PIX_DIV`=1, `p_tick` is constantly high after reset.
- Horizontal counter:
  - On `p_tick`: `pix_x` = (`pix_x`==`H_TOTAL`-1) ? 0 : `pix_x`+1.
- Vertical counter:
  - On `p_tick` and `pix_x`==`H_TOTAL`-1: `pix_y` = (`pix_y`==`V_TOTAL`-1) ? 0 : `pix_y`+1.
  - Both counters wrap on the same edge at end of frame (799,524)→(0,0).
- Sync outputs:
  - `hsync`, `vsync` are registered and computed from the next-state counter values, so they align cycle-exactly with `pix_x`/`pix_y`. There is no extra latency and no glitches.
  - `hsync`=0 iff `pix_x` in [`H_DISP`+`H_FP`, `H_DISP`+`H_FP`+`H_SYNC`-1] = [656,751].
  - `vsync`=0 iff `pix_y` in [`V_DISP`+`V_FP`, `V_DISP`+`V_FP`+`V_SYNC`-1] = [490,491].
- `video_on`:
  - Combinational: (`pix_x`<`H_DISP`) && (`pix_y`<`V_DISP`).
- `refr_tick`:
  - Combinational: `p_tick` && `pix_x`==0 && `pix_y`==`V_DISP`+1 (481).
  - Exactly one clk wide, once per frame, never inside the visible area.
- Coordinate stability:
  - All coordinate outputs are stable for `PIX_DIV` clocks per pixel.
  - Consumers sample on any clock; registered consumers should qualify with `p_tick`.

Optional Feature:
- Macro: `VGA_SYNC_FRAME_CNT_EN`.
- Defined:
  - Adds output `frame_cnt` [7:0], reset 0.
  - Increments by 1 (mod 256) on the edge where the counters wrap (799,524)→(0,0).
- Undefined:
  - Port and logic are absent; all other behaviour is identical.

Decomposition:
- Package `vga_timing_pkg`: the 640x480 timing constants, derived `H_TOTAL`/`V_TOTAL`, sync window bounds, and `CW`. These are shared with the renderers for bounds checks.
- Sub-module `vga_pix_tick`: parameterised `PIX_DIV` clock-enable divider with synchronous reset, output `p_tick`.

Test Plan:
- Release reset, `PIX_DIV`=2 → `p_tick` period is 2 clks; `pix_x` reaches 799 then 0 after exactly 1600 clks; `pix_y` increments to 1 on that same edge.
- Full frame → `hsync` low for exactly 96 pixels (192 clks) starting at `pix_x`=656 on every line; `vsync` low exactly while `pix_y`∈{490,491}; frame length 800×525×2 = 840000 clks.
- Check `video_on` → high at (0,0) and (639,479); low at (640,0), (0,480) and (799,524).
- Count `refr_tick` over 3 frames → exactly 3 pulses, each 1 clk wide, each at `pix_x`=0, `pix_y`=481.
- Assert `reset` for 1 clk at `pix_x`=700, `pix_y`=300 → next edge gives (0,0), `hsync`=1, `vsync`=1; normal counting resumes with no missing or extra `p_tick`.
- `VGA_SYNC_FRAME_CNT_EN` defined → `frame_cnt` 0→1→2 across two frame wraps, wraps 255→0; undefined build elaborates without the port.
